inst_stats_mon: RTL and testbench

- Downstream consumer of the pipeline top's fetched-instruction stream (inst_out) and its valid / opr_finished strobes.
- Decodes each valid MIPS-lite instruction word by class and keeps saturating counters.
- Detects program end (HALT opcode or an external opr_finished abort) and freezes.
- Exposes a registered counter readout port for the testbench and run-summary logic.

---
 rtl/inst_stats_mon_if.sv | 27 ++
 rtl/inst_stats_mon.sv | 158 +++++++++++++++
 tb/tb_inst_stats_mon.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/inst_stats_mon_if.sv
// Bundle of stream inputs, control strobes and statistics readout for inst_stats_mon.
interface inst_stats_mon_if #(
   parameter int unsigned CNT_W = 32
);
   logic             valid;
   logic [31:0]      inst;
   logic             opr_finished;
   logic             clear;
   logic [2:0]       rd_sel;
   logic [CNT_W-1:0] rd_data;
   logic             halted;
   logic             done;
   logic             aborted;
   logic             illegal_seen;

   // Producer side: pipeline top plus testbench / run-summary logic
   modport master (
      output valid, inst, opr_finished, clear, rd_sel,
      input  rd_data, halted, done, aborted, illegal_seen
   );

   // Monitor side
   modport slave (
      input  valid, inst, opr_finished, clear, rd_sel,
      output rd_data, halted, done, aborted, illegal_seen
   );
endinterface

// File: rtl/inst_stats_mon.sv
// Instruction statistics monitor: classifies each valid fetched MIPS-lite word,
// keeps saturating per-class counters, freezes on HALT or external abort and
// offers a registered counter readout.
module inst_stats_mon #(
   parameter int unsigned CNT_W = 32
) (
   input logic             clk,
   input logic             reset,
   inst_stats_mon_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      HALTED
   } state_e;

   // Counter slots, matching the rd_sel readout map
   localparam int unsigned IDX_TOTAL   = 0;
   localparam int unsigned IDX_ARITH   = 1;
   localparam int unsigned IDX_LOGICAL = 2;
   localparam int unsigned IDX_MEMORY  = 3;
   localparam int unsigned IDX_CONTROL = 4;
   localparam int unsigned IDX_CYCLES  = 5;
   localparam int unsigned IDX_BUBBLES = 6;
   localparam int unsigned IDX_ILLEGAL = 7;
   localparam int unsigned NUM_CNT     = 8;

   localparam logic [5:0] OP_HALT = 6'h11;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q [NUM_CNT];
   logic [CNT_W-1:0] cnt_d [NUM_CNT];
   logic [CNT_W-1:0] rd_data_q, rd_data_d;
   logic             done_q, done_d;
   logic             aborted_q, aborted_d;
   logic             illegal_q, illegal_d;

   logic [5:0]       opcode;
   logic             is_bubble;
   logic             is_arith;
   logic             is_logical;
   logic             is_memory;
   logic             is_control;
   logic             is_halt;
   logic             is_illegal;
   logic             active;

   // Increment that sticks at all-ones instead of wrapping
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      logic [CNT_W-1:0] one;
      one = {{(CNT_W-1){1'b0}}, 1'b1};
      return (&v) ? v : v + one;
   endfunction

   // Opcode class decode; the all-zero word is a bubble even though opcode 0 is arith
   always_comb begin
      opcode     = bus.inst[31:26];
      is_bubble  = (bus.inst == 32'h0000_0000);
      is_arith   = !is_bubble && (opcode <= 6'h05);
      is_logical = (opcode >= 6'h06) && (opcode <= 6'h0B);
      is_memory  = (opcode >= 6'h0C) && (opcode <= 6'h0D);
      is_control = (opcode >= 6'h0E) && (opcode <= 6'h11);
      is_halt    = (opcode == OP_HALT);
      is_illegal = (opcode >= 6'h12);
   end

   // Next-state, counter update and flag logic
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      done_d    = 1'b0;
      aborted_d = aborted_q;
      illegal_d = illegal_q;
      rd_data_d = cnt_q[bus.rd_sel];
      active    = 1'b0;

      // IDLE only wakes on a valid word, which is then handled exactly like RUN
      case (state_q)
         IDLE:    active = bus.valid;
         RUN:     active = 1'b1;
         HALTED:  active = 1'b0;
         default: active = 1'b0;
      endcase

      if (active) begin
         state_d = RUN;
         cnt_d[IDX_CYCLES] = sat_inc(cnt_q[IDX_CYCLES]);

         if (bus.valid) begin
            if (is_bubble) begin
               cnt_d[IDX_BUBBLES] = sat_inc(cnt_q[IDX_BUBBLES]);
            end else begin
               cnt_d[IDX_TOTAL] = sat_inc(cnt_q[IDX_TOTAL]);
               if (is_arith)   cnt_d[IDX_ARITH]   = sat_inc(cnt_q[IDX_ARITH]);
               if (is_logical) cnt_d[IDX_LOGICAL] = sat_inc(cnt_q[IDX_LOGICAL]);
               if (is_memory)  cnt_d[IDX_MEMORY]  = sat_inc(cnt_q[IDX_MEMORY]);
               if (is_control) cnt_d[IDX_CONTROL] = sat_inc(cnt_q[IDX_CONTROL]);
               if (is_illegal) begin
                  cnt_d[IDX_ILLEGAL] = sat_inc(cnt_q[IDX_ILLEGAL]);
                  illegal_d          = 1'b1;
               end
            end
         end

         // HALT takes precedence over a coincident abort, so aborted stays clear
         if (bus.valid && !is_bubble && is_halt) begin
            state_d = HALTED;
            done_d  = 1'b1;
         end else if (bus.opr_finished) begin
            state_d   = HALTED;
            done_d    = 1'b1;
            aborted_d = 1'b1;
         end
      end

      // Clear overrides everything, including the same-cycle instruction
      if (bus.clear) begin
         state_d   = IDLE;
         done_d    = 1'b0;
         aborted_d = 1'b0;
         illegal_d = 1'b0;
         for (int unsigned i = 0; i < NUM_CNT; i++) begin
            cnt_d[i] = '0;
         end
      end
   end

   // State, counter, flag and readout registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         rd_data_q <= '0;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
         illegal_q <= 1'b0;
         for (int unsigned i = 0; i < NUM_CNT; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         rd_data_q <= rd_data_d;
         done_q    <= done_d;
         aborted_q <= aborted_d;
         illegal_q <= illegal_d;
         for (int unsigned i = 0; i < NUM_CNT; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign bus.rd_data      = rd_data_q;
   assign bus.halted       = (state_q == HALTED);
   assign bus.done         = done_q;
   assign bus.aborted      = aborted_q;
   assign bus.illegal_seen = illegal_q;

endmodule

// File: tb/tb_inst_stats_mon.sv
// Bench for inst_stats_mon: two instances (32-bit and 4-bit counters) fed the
// same stream and compared each cycle against a counting reference model.
module tb_inst_stats_mon;

   logic clk;
   logic reset;

   inst_stats_mon_if #(.CNT_W(32)) bus32 ();
   inst_stats_mon_if #(.CNT_W(4))  bus4 ();

   inst_stats_mon #(.CNT_W(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32.slave));
   inst_stats_mon #(.CNT_W(4))  dut4  (.clk(clk), .reset(reset), .bus(bus4.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: per-width counter arrays plus run flags
   longint unsigned m_cnt [2][8];
   longint unsigned m_max [2];
   longint unsigned m_rd  [2];
   bit m_started, m_halted, m_done, m_aborted, m_ill;

   localparam logic [31:0] W_ADDI = 32'h0422_0005;  // op 0x01
   localparam logic [31:0] W_ORI  = 32'h1C43_00FF;  // op 0x07
   localparam logic [31:0] W_LDW  = 32'h3064_0010;  // op 0x0C
   localparam logic [31:0] W_BEQ  = 32'h3885_FFFC;  // op 0x0E
   localparam logic [31:0] W_HALT = 32'h4400_0000;  // op 0x11
   localparam logic [31:0] W_ADD  = 32'h0022_1800;  // op 0x00, non-zero
   localparam logic [31:0] W_SUB  = 32'h0843_2000;  // op 0x02
   localparam logic [31:0] W_ILL  = 32'hFC00_0001;  // op 0x3F

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_rd[k] = 0;
         for (int j = 0; j < 8; j++) m_cnt[k][j] = 0;
      end
      m_started = 0; m_halted = 0; m_done = 0; m_aborted = 0; m_ill = 0;
   endtask

   task automatic m_inc(input int idx);
      for (int k = 0; k < 2; k++)
         if (m_cnt[k][idx] < m_max[k]) m_cnt[k][idx] = m_cnt[k][idx] + 1;
   endtask

   function automatic int m_class(input logic [31:0] w);
      int op;
      op = int'(w[31:26]);
      if (op <= 5)  return 1;
      if (op <= 11) return 2;
      if (op <= 13) return 3;
      if (op <= 17) return 4;
      return 7;
   endfunction

   // One clock of the behavioural rules
   task automatic model_clock(input bit v, input logic [31:0] w, input bit of,
                              input bit clr, input int sel);
      int c;
      for (int k = 0; k < 2; k++) m_rd[k] = m_cnt[k][sel];
      m_done = 0;
      if (clr) begin
         for (int k = 0; k < 2; k++)
            for (int j = 0; j < 8; j++) m_cnt[k][j] = 0;
         m_started = 0; m_halted = 0; m_aborted = 0; m_ill = 0;
      end else if (!m_halted && (m_started || v)) begin
         m_started = 1;
         m_inc(5);
         if (v) begin
            if (w == 32'h0) m_inc(6);
            else begin
               c = m_class(w);
               m_inc(0);
               m_inc(c);
               if (c == 7) m_ill = 1;
            end
         end
         if (v && w[31:26] == 6'h11) begin
            m_halted = 1; m_done = 1;
         end else if (of) begin
            m_halted = 1; m_done = 1; m_aborted = 1;
         end
      end
   endtask

   task automatic check_all(input string w);
      chk({w, "/rd32"},   64'(bus32.rd_data),  m_rd[0]);
      chk({w, "/rd4"},    64'(bus4.rd_data),   m_rd[1]);
      chk({w, "/halt32"}, 64'(bus32.halted),   64'(m_halted));
      chk({w, "/halt4"},  64'(bus4.halted),    64'(m_halted));
      chk({w, "/done32"}, 64'(bus32.done),     64'(m_done));
      chk({w, "/done4"},  64'(bus4.done),      64'(m_done));
      chk({w, "/abrt32"}, 64'(bus32.aborted),  64'(m_aborted));
      chk({w, "/abrt4"},  64'(bus4.aborted),   64'(m_aborted));
      chk({w, "/ill32"},  64'(bus32.illegal_seen), 64'(m_ill));
      chk({w, "/ill4"},   64'(bus4.illegal_seen),  64'(m_ill));
   endtask

   task automatic drive(input bit v, input logic [31:0] w, input bit of,
                        input bit clr, input int sel);
      bus32.valid = v; bus32.inst = w; bus32.opr_finished = of;
      bus32.clear = clr; bus32.rd_sel = 3'(sel);
      bus4.valid  = v; bus4.inst  = w; bus4.opr_finished  = of;
      bus4.clear  = clr; bus4.rd_sel  = 3'(sel);
   endtask

   // Apply inputs after a falling edge, clock once, check at the next falling edge
   task automatic step(input string w, input bit v, input logic [31:0] inst,
                       input bit of, input bit clr, input int sel);
      drive(v, inst, of, clr, sel);
      @(posedge clk);
      model_clock(v, inst, of, clr, sel);
      @(negedge clk);
      check_all(w);
   endtask

   // Read every counter; optional fixed expectations where counters are known frozen
   task automatic sweep(input string w, input bit use32, input longint unsigned e32[8],
                        input bit use4, input longint unsigned e4[8]);
      for (int s = 0; s < 8; s++) begin
         step(w, 0, 32'h0, 0, 0, s);
         if (use32) chk({w, "/const32"}, 64'(bus32.rd_data), e32[s]);
         if (use4)  chk({w, "/const4"},  64'(bus4.rd_data),  e4[s]);
      end
   endtask

   initial begin
      logic [31:0] rw;
      longint unsigned none[8];
      for (int j = 0; j < 8; j++) none[j] = 0;
      m_max[0] = 64'hFFFF_FFFF;
      m_max[1] = 15;

      // Reset state
      reset = 1'b1;
      drive(0, 32'h0, 0, 0, 0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      check_all("reset");
      reset = 1'b0;

      // 1: mixed stream ending in HALT
      step("t1", 1, W_ADDI, 0, 0, 0);
      step("t1", 1, W_ORI,  0, 0, 0);
      step("t1", 1, W_LDW,  0, 0, 0);
      step("t1", 1, W_BEQ,  0, 0, 0);
      step("t1", 1, 32'h0,  0, 0, 0);
      step("t1", 1, W_HALT, 0, 0, 0);
      chk("t1.done_pulse", 64'(bus32.done), 64'd1);
      step("t1", 0, 32'h0, 0, 0, 0);
      chk("t1.done_gone", 64'(bus32.done), 64'd0);
      chk("t1.halted", 64'(bus32.halted), 64'd1);
      sweep("t1sw", 1, '{5, 1, 1, 1, 2, 6, 1, 0}, 1, '{5, 1, 1, 1, 2, 6, 1, 0});

      // 2: words while HALTED are ignored
      for (int i = 0; i < 10; i++) step("t2", 1, W_ADD, i == 3, 0, 5);
      sweep("t2sw", 1, '{5, 1, 1, 1, 2, 6, 1, 0}, 1, '{5, 1, 1, 1, 2, 6, 1, 0});

      // 3: idle RUN cycles then abort with a valid SUB; then HALT+abort together
      step("t3", 0, 32'h0, 0, 1, 0);
      step("t3", 1, W_ADD, 0, 0, 0);
      for (int i = 0; i < 4; i++) step("t3", 0, 32'h0, 0, 0, 5);
      step("t3", 1, W_SUB, 1, 0, 1);
      chk("t3.aborted", 64'(bus32.aborted), 64'd1);
      sweep("t3sw", 1, '{2, 2, 0, 0, 0, 6, 0, 0}, 0, none);
      step("t3b", 0, 32'h0, 0, 1, 0);
      step("t3b", 1, W_ADD, 0, 0, 0);
      step("t3b", 1, W_HALT, 1, 0, 0);
      chk("t3b.not_aborted", 64'(bus32.aborted), 64'd0);
      chk("t3b.halted", 64'(bus32.halted), 64'd1);

      // 4: illegal opcode, then clear with a same-cycle valid ADD
      step("t4", 0, 32'h0, 0, 1, 0);
      step("t4", 1, W_ADD, 0, 0, 0);
      step("t4", 1, W_ILL, 0, 0, 7);
      chk("t4.ill_seen", 64'(bus32.illegal_seen), 64'd1);
      step("t4", 1, W_ADD, 0, 0, 7);
      chk("t4.ill_cnt", 64'(bus32.rd_data), 64'd1);
      step("t4", 1, W_ADD, 0, 1, 0);
      chk("t4.ill_cleared", 64'(bus32.illegal_seen), 64'd0);
      sweep("t4sw", 1, '{0, 0, 0, 0, 0, 0, 0, 0}, 1, '{0, 0, 0, 0, 0, 0, 0, 0});

      // 5: saturation of the narrow instance
      for (int i = 0; i < 20; i++) step("t5", 1, W_ADDI, 0, 0, 1);
      sweep("t5sw", 0, none, 1, '{15, 15, 0, 0, 0, 15, 0, 0});

      // 6: asynchronous reset between edges mid-run
      step("t6", 0, 32'h0, 0, 1, 0);
      step("t6", 1, W_ADD, 0, 0, 5);
      step("t6", 1, W_SUB, 0, 0, 5);
      step("t6", 1, W_ORI, 0, 0, 5);
      #2 reset = 1'b1;
      #1;
      model_reset();
      check_all("t6async");
      @(negedge clk);
      check_all("t6held");
      reset = 1'b0;
      step("t6post", 1, W_LDW, 0, 0, 0);
      step("t6post", 1, W_LDW, 0, 0, 3);
      step("t6post", 0, 32'h0, 0, 0, 3);
      chk("t6.mem_from0", 64'(bus32.rd_data), 64'd2);

      // Randomized traffic
      step("rnd", 0, 32'h0, 0, 1, 0);
      for (int i = 0; i < 500; i++) begin
         rw = $urandom;
         if ($urandom_range(0, 7) == 0) rw = 32'h0;
         step("rnd", $urandom_range(0, 3) != 0, rw, $urandom_range(0, 39) == 0,
              $urandom_range(0, 24) == 0, int'($urandom_range(0, 7)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
